// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between the I-cache miss path and the
// D-cache miss/write-through paths: single-word stores and 8-word block fills.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_miss,
  input  logic [15:0]      i_miss_addr,
  input  logic             d_miss,
  input  logic [15:0]      d_miss_addr,
  input  logic             d_wr_req,
  input  logic [15:0]      d_wr_addr,
  input  logic [15:0]      d_wr_data,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data_out,
  input  logic [15:0]      mem_data_in,
  input  logic             mem_data_valid,
  output logic [15:0]      fill_data,
  output logic [IDX_W-1:0] fill_word,
  output logic             i_fill_we,
  output logic             d_fill_we,
  output logic             i_fill_done,
  output logic             d_fill_done,
  output logic             d_wr_ack,
  output logic             busy
);

  localparam int BLK_W = 15 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} state_t;

  // Handshake: each request is a level held by its requester until the
  // matching one-cycle done/ack pulse; the arbiter never drops a held request.
  state_t           state;
  logic [BLK_W-1:0] blk;
  logic [15:0]      wr_addr;
  logic [15:0]      wr_data;
  logic [IDX_W:0]   ic;
  logic [IDX_W-1:0] rc;

  logic filling;
  logic issuing;
  logic rx_last;
  logic unused_addr_bits;

  assign filling = (state == FILL_D) || (state == FILL_I);
  // ic's top bit sets once the last word of the block has been issued
  assign issuing = filling && !ic[IDX_W];
  assign rx_last = filling && mem_data_valid && (rc == LAST_WORD);
  assign unused_addr_bits = ^{i_miss_addr[IDX_W:0], d_miss_addr[IDX_W:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      blk     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      ic      <= '0;
      rc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ic <= '0;
          rc <= '0;
          if (d_wr_req) begin
            wr_addr <= d_wr_addr;
            wr_data <= d_wr_data;
            state   <= WRITE;
          end else if (d_miss) begin
            blk   <= d_miss_addr[15:IDX_W+1];
            state <= FILL_D;
          end else if (i_miss) begin
            blk   <= i_miss_addr[15:IDX_W+1];
            state <= FILL_I;
          end
        end
        WRITE: state <= IDLE;
        FILL_D, FILL_I: begin
          if (issuing)        ic <= ic + 1'b1;
          if (mem_data_valid) rc <= rc + 1'b1;
          if (rx_last)        state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    if (state == WRITE) begin
      mem_enable   = 1'b1;
      mem_wr       = 1'b1;
      mem_addr     = wr_addr;
      mem_data_out = wr_data;
    end else if (issuing) begin
      mem_enable = 1'b1;
      mem_addr   = {blk, ic[IDX_W-1:0], 1'b0};
    end
  end

  assign fill_data   = (filling && mem_data_valid) ? mem_data_in : '0;
  assign fill_word   = filling ? rc : '0;
  assign i_fill_we   = (state == FILL_I) && mem_data_valid;
  assign d_fill_we   = (state == FILL_D) && mem_data_valid;
  assign i_fill_done = (state == FILL_I) && rx_last;
  assign d_fill_done = (state == FILL_D) && rx_last;
  assign d_wr_ack    = (state == WRITE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: 4-cycle pipelined memory model, per-scenario tasks
// checking a cycle timeline derived from grant-relative latencies.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mem_key = 16'h0000;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  // Memory model: a read seen at an edge returns address ^ key four cycles on
  logic [15:0] pipe_a[4] = '{default: 16'h0};
  logic        pipe_v[4] = '{default: 1'b0};
  always @(posedge clk) begin
    pipe_v[0] <= mem_enable && !mem_wr;
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < 4; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign mem_data_valid = pipe_v[3];
  assign mem_data_in    = pipe_v[3] ? (pipe_a[3] ^ mem_key) : 16'hDEAD;

  // {mem_enable, mem_wr, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy}
  function automatic logic [7:0] obs_flags();
    return {mem_enable, mem_wr, i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy};
  endfunction

  // Called at mid-cycle 0 with the request already raised; returns at mid-cycle 13.
  task automatic expect_fill(input bit is_d, input logic [15:0] addr, input int drop_c,
                             input int wr_c, input string tag);
    logic [15:0] exp_q[$];
    logic [15:0] base, exp_a, exp_d;
    logic [7:0]  ef;
    bit          en, we;
    base = addr & 16'hFFF0;
    for (int w = 0; w < 8; w++) exp_q.push_back((base + 16'(2 * w)) ^ mem_key);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      en = (c <= 8);
      we = (c >= 5) && (c <= 12);
      ef = {en, 1'b0, we && !is_d, we && is_d, (c == 12) && !is_d, (c == 12) && is_d,
            1'b0, c <= 12};
      n_cmp++;
      if (obs_flags() !== ef) begin
        n_err++;
        $display("FAIL %s flags cyc%0d: got %b want %b", tag, c, obs_flags(), ef);
      end
      if (en) begin
        exp_a = base + 16'(2 * (c - 1));
        n_cmp++;
        if (mem_addr !== exp_a) begin
          n_err++;
          $display("FAIL %s mem_addr cyc%0d: got %h want %h", tag, c, mem_addr, exp_a);
        end
      end
      if (we) begin
        exp_d = exp_q.pop_front();
        n_cmp++;
        if ({fill_word, fill_data} !== {3'(c - 5), exp_d}) begin
          n_err++;
          $display("FAIL %s fill cyc%0d: got w%0d %h want w%0d %h", tag, c,
                   fill_word, fill_data, c - 5, exp_d);
        end
      end
      if (c == drop_c) begin
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
      end
      if (c == wr_c) d_wr_req = 1'b1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s words_left: got %0d want 0", tag, exp_q.size());
    end
  endtask

  // Called at mid-cycle 0 with d_wr_req raised; returns at mid-cycle 2.
  task automatic expect_write(input logic [15:0] addr, input logic [15:0] data,
                              input string tag);
    @(negedge clk);
    n_cmp++;
    if ({obs_flags(), mem_addr, mem_data_out} !== {8'b1100_0011, addr, data}) begin
      n_err++;
      $display("FAIL %s write: got %b %h %h want 11000011 %h %h", tag, obs_flags(),
               mem_addr, mem_data_out, addr, data);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_flags() !== 8'b0) begin
      n_err++;
      $display("FAIL %s post_write_idle: got %b want 00000000", tag, obs_flags());
    end
    d_wr_req = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_flags() !== 8'b0) begin
        n_err++;
        $display("FAIL %s idle%0d: got %b want 00000000", tag, c, obs_flags());
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({obs_flags(), mem_addr, mem_data_out, fill_data, fill_word} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b %h %h %h %0d want all 0", obs_flags(),
               mem_addr, mem_data_out, fill_data, fill_word);
    end
    i_miss = 1'b1;
    i_miss_addr = 16'h4444;
    idle_check(2, "held_in_reset");
    i_miss = 1'b0;
    rst_n  = 1'b1;
    idle_check(2, "after_reset");
  endtask

  task automatic test_i_fill();
    mem_key = 16'h0000;
    i_miss_addr = 16'h1234;
    i_miss = 1'b1;
    expect_fill(1'b0, 16'h1234, 13, 0, "i_fill_1234");
    mem_key = 16'($urandom);
    i_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    expect_fill(1'b0, i_miss_addr, 13, 0, "i_fill_rand");
    idle_check(1, "i_fill");
  endtask

  task automatic test_priority();
    mem_key = 16'h0000;
    d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss_addr = 16'h2000; i_miss_addr = 16'h3000;
    d_wr_req = 1'b1; d_miss = 1'b1; i_miss = 1'b1;
    expect_write(16'h0040, 16'hBEEF, "prio_wr");
    expect_fill(1'b1, 16'h2000, 13, 0, "prio_d");
    expect_fill(1'b0, 16'h3000, 13, 0, "prio_i");
    idle_check(2, "prio");
  endtask

  task automatic test_wr_during_fill();
    logic [15:0] wa, wd;
    mem_key = 16'($urandom);
    wa = 16'($urandom); wd = 16'($urandom);
    d_wr_addr = wa; d_wr_data = wd;
    i_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    expect_fill(1'b0, i_miss_addr, 13, 3, "wr_mid_fill");
    expect_write(wa, wd, "wr_after_fill");
    idle_check(1, "wr_mid_fill");
  endtask

  task automatic test_reset_mid_fill();
    mem_key = 16'($urandom);
    d_miss_addr = 16'($urandom);
    d_miss = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs_flags(), mem_addr, mem_data_out, fill_data, fill_word} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_fill: got %b %h %h %h %0d want all 0", obs_flags(),
               mem_addr, mem_data_out, fill_data, fill_word);
    end
    d_miss = 1'b0;
    for (int c = 8; c <= 13; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_flags() !== 8'b0) begin
        n_err++;
        $display("FAIL stale_valid cyc%0d: got %b want 00000000", c, obs_flags());
      end
      if (c == 9) rst_n = 1'b1;
    end
    d_miss_addr = 16'($urandom);
    d_miss = 1'b1;
    expect_fill(1'b1, d_miss_addr, 13, 0, "refill");
    idle_check(1, "refill");
  endtask

  task automatic test_drop_mid_fill();
    mem_key = 16'($urandom);
    i_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    expect_fill(1'b0, i_miss_addr, 4, 0, "drop_mid_fill");
    idle_check(4, "drop_mid_fill");
  endtask

  task automatic test_top_block();
    mem_key = 16'h0000;
    d_miss_addr = 16'hFFFF;
    d_miss = 1'b1;
    expect_fill(1'b1, 16'hFFFF, 13, 0, "top_block");
    idle_check(1, "top_block");
  endtask

  task automatic test_random();
    int mask;
    for (int k = 0; k < 12; k++) begin
      mem_key = 16'($urandom);
      mask = $urandom_range(1, 7);
      d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
      d_miss_addr = 16'($urandom); i_miss_addr = 16'($urandom);
      d_wr_req = mask[2]; d_miss = mask[1]; i_miss = mask[0];
      if (mask[2]) expect_write(d_wr_addr, d_wr_data, "rand_wr");
      if (mask[1]) expect_fill(1'b1, d_miss_addr, 13, 0, "rand_d");
      if (mask[0]) expect_fill(1'b0, i_miss_addr, 13, 0, "rand_i");
      idle_check($urandom_range(1, 3), "rand");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    test_reset();
    test_i_fill();
    test_priority();
    test_wr_during_fill();
    test_reset_mid_fill();
    test_drop_mid_fill();
    test_top_block();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
